// File: rtl/display_mode_pkg.sv
`default_nettype none
// ============================================================================
// Module  : display_mode_pkg
// Purpose : Shared types and constants for the matrix display block.
//           Holds the display state encoding, the error codes reported on
//           error_code (ERR_NONE, ERR_DIM_RANGE, ERR_SLOT_EMPTY), ASCII
//           constants and a small digit-classification helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package display_mode_pkg;

  // Display state encoding; values are visible externally on sub_state.
  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_WAIT_SLOT    = 4'd1,
    ST_QUERY        = 4'd2,
    ST_HDR          = 4'd3,
    ST_RD_ISSUE     = 4'd4,
    ST_RD_WAIT      = 4'd5,
    ST_SEND_VAL     = 4'd6,
    ST_SEND_SPACE   = 4'd7,
    ST_SEND_NEWLINE = 4'd8,
    ST_DONE         = 4'd9
  } disp_state_e;

  // Error codes shared with the rest of the matrix subsystem.
  localparam logic [3:0] ERR_NONE       = 4'd0;
  localparam logic [3:0] ERR_DIM_RANGE  = 4'd1;
  localparam logic [3:0] ERR_SLOT_EMPTY = 4'd2;

  // ASCII bytes emitted by the display path.
  localparam logic [7:0] C_CH_BANG  = 8'h21;  // '!'
  localparam logic [7:0] C_CH_SPACE = 8'h20;  // ' '
  localparam logic [7:0] C_CH_LF    = 8'h0A;  // line feed
  localparam logic [7:0] C_CH_X     = 8'h78;  // 'x'

  // True when the byte is an ASCII decimal digit '0'..'9'.
  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_mode_hex_ascii.sv
`default_nettype none
// ============================================================================
// Module  : hex_ascii
// Purpose : Combinational conversion of a 4-bit value to its upper-case
//           ASCII hex character ('0'-'9', 'A'-'F').
// Ports   : value [3:0] in  - nibble to convert
//           ascii [7:0] out - ASCII character
// Revision: 1.0 - initial release
// ============================================================================
module hex_ascii (
  input  logic [3:0] value,
  output logic [7:0] ascii
);

  always_comb begin
    if (value < 4'd10) begin
      ascii = {4'h3, value};            // '0' is 0x30
    end else begin
      ascii = 8'h37 + {4'h0, value};    // 10 + 0x37 = 'A'
    end
  end

endmodule
`default_nettype wire

// File: rtl/display_mode.sv
`default_nettype none
// ============================================================================
// Module  : display_mode
// Purpose : Prints a committed matrix slot over a byte transmitter. Waits for
//           an ASCII slot digit, looks the slot up, then streams every
//           element as one hex digit followed by a space, with a line feed
//           after each row.
// Config  : DISPLAY_HEADER_EN - when defined, each matrix is preceded by a
//           "<m>x<n>\n" header line.
// Ports   : clk, rst_n                  clock, async active-low reset
//           mode_active, timeout_reset  enable, abort-to-IDLE request
//           rx_data, rx_done            received byte and its strobe
//           clear_rx_buffer             receive-consumed pulse
//           tx_data, tx_start, tx_busy  transmitter byte, pulse, busy
//           query_*                     slot lookup handshake and result
//           mem_rd_en/addr/data         element memory read (1-cycle latency)
//           sub_state, error_code       current state, last error
// Revision: 1.0 - initial release
// ============================================================================
`ifndef ELEMENT_WIDTH
`define ELEMENT_WIDTH 8
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 10
`endif

module display_mode
  import display_mode_pkg::*;
#(
  parameter int ELEMENT_WIDTH = `ELEMENT_WIDTH,
  parameter int ADDR_WIDTH    = `BRAM_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode_active,
  input  logic                     timeout_reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  output logic                     clear_rx_buffer,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic                     query_req,
  output logic [3:0]               query_slot,
  input  logic                     query_valid,
  input  logic                     query_hit,
  input  logic [3:0]               query_m,
  input  logic [3:0]               query_n,
  input  logic [ADDR_WIDTH-1:0]    query_addr,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
  output logic [3:0]               sub_state,
  output logic [3:0]               error_code
);

  disp_state_e           state_q, state_d;
  logic [3:0]            err_q, err_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  tx_hold_q, tx_hold_d;
  logic                  query_req_q, query_req_d;
  logic [3:0]            slot_q, slot_d;
  logic                  clear_q, clear_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [3:0]            m_q, m_d;
  logic [3:0]            n_q, n_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [7:0]            idx_q, idx_d;
  logic [3:0]            col_q, col_d;
  logic [3:0]            data_q, data_d;
  logic                  miss_q, miss_d;
  logic [1:0]            hdr_step_q, hdr_step_d;

  logic [7:0]            w_prod;
  logic [7:0]            w_last_idx;
  logic                  w_can_send;
  logic [3:0]            w_hex_in;
  logic [7:0]            w_hex_char;

  // Only the low nibble of each element is displayed.
  generate
    if (ELEMENT_WIDTH > 4) begin : g_unused_data
      logic w_unused_hi;
      assign w_unused_hi = ^mem_rd_data[ELEMENT_WIDTH-1:4];
    end
  endgenerate

  assign w_prod     = {4'd0, m_q} * {4'd0, n_q};
  assign w_last_idx = w_prod - 8'd1;

  // A send is allowed only when the transmitter is idle and neither the
  // cycle carrying our last tx_start nor the one after it is current: the
  // transmitter needs that cycle to raise tx_busy before we trust it again.
  assign w_can_send = !tx_busy && !tx_start_q && !tx_hold_q;

`ifdef DISPLAY_HEADER_EN
  assign w_hex_in = (state_q == ST_HDR) ? ((hdr_step_q == 2'd0) ? m_q : n_q)
                                        : data_q;
`else
  assign w_hex_in = data_q;
`endif

  hex_ascii u_hex_ascii (
    .value (w_hex_in),
    .ascii (w_hex_char)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    tx_hold_d   = tx_start_q;
    query_req_d = 1'b0;
    slot_d      = slot_q;
    clear_d     = 1'b0;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    m_d         = m_q;
    n_d         = n_q;
    base_d      = base_q;
    idx_d       = idx_q;
    col_d       = col_q;
    data_d      = data_q;
    miss_d      = miss_q;
    hdr_step_d  = hdr_step_q;

    if (!mode_active) begin
      // Disabled: park in IDLE and drop any output in progress.
      state_d    = ST_IDLE;
      miss_d     = 1'b0;
      hdr_step_d = 2'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_SLOT;
        end

        ST_WAIT_SLOT: begin
          if (timeout_reset) begin
            state_d = ST_IDLE;
          end else if (rx_done) begin
            clear_d = 1'b1;
            if (is_digit(rx_data)) begin
              slot_d      = rx_data[3:0];
              err_d       = ERR_NONE;
              query_req_d = 1'b1;
              state_d     = ST_QUERY;
            end else begin
              err_d = ERR_DIM_RANGE;
              if (w_can_send) begin
                tx_data_d  = C_CH_BANG;
                tx_start_d = 1'b1;
              end
            end
          end
        end

        ST_QUERY: begin
          if (timeout_reset) begin
            miss_d  = 1'b0;
            state_d = ST_IDLE;
          end else if (miss_q) begin
            // Miss already reported; waiting for the transmitter to free up.
            if (w_can_send) begin
              tx_data_d  = C_CH_BANG;
              tx_start_d = 1'b1;
              miss_d     = 1'b0;
              state_d    = ST_WAIT_SLOT;
            end
          end else if (query_valid) begin
            if (query_hit) begin
              m_d        = query_m;
              n_d        = query_n;
              base_d     = query_addr;
              idx_d      = 8'd0;
              col_d      = 4'd0;
              hdr_step_d = 2'd0;
              state_d    = ST_HDR;
            end else begin
              err_d = ERR_SLOT_EMPTY;
              if (w_can_send) begin
                tx_data_d  = C_CH_BANG;
                tx_start_d = 1'b1;
                state_d    = ST_WAIT_SLOT;
              end else begin
                miss_d = 1'b1;
              end
            end
          end else begin
            query_req_d = 1'b1;
          end
        end

        ST_HDR: begin
`ifdef DISPLAY_HEADER_EN
          if (w_can_send) begin
            tx_start_d = 1'b1;
            hdr_step_d = hdr_step_q + 2'd1;
            unique case (hdr_step_q)
              2'd0:    tx_data_d = w_hex_char;
              2'd1:    tx_data_d = C_CH_X;
              2'd2:    tx_data_d = w_hex_char;
              default: begin
                tx_data_d = C_CH_LF;
                state_d   = ST_RD_ISSUE;
              end
            endcase
          end
`else
          state_d = ST_RD_ISSUE;
`endif
        end

        ST_RD_ISSUE: begin
          rd_en_d   = 1'b1;
          rd_addr_d = base_q + ADDR_WIDTH'(idx_q);
          state_d   = ST_RD_WAIT;
        end

        ST_RD_WAIT: begin
          // First cycle here carries the read strobe; data arrives the next.
          if (!rd_en_q) begin
            data_d  = mem_rd_data[3:0];
            state_d = ST_SEND_VAL;
          end
        end

        ST_SEND_VAL: begin
          if (w_can_send) begin
            tx_data_d  = w_hex_char;
            tx_start_d = 1'b1;
            state_d    = ST_SEND_SPACE;
          end
        end

        ST_SEND_SPACE: begin
          if (w_can_send) begin
            tx_data_d  = C_CH_SPACE;
            tx_start_d = 1'b1;
            if (col_q + 4'd1 == n_q) begin
              state_d = ST_SEND_NEWLINE;
            end else begin
              col_d   = col_q + 4'd1;
              idx_d   = idx_q + 8'd1;
              state_d = ST_RD_ISSUE;
            end
          end
        end

        ST_SEND_NEWLINE: begin
          if (w_can_send) begin
            tx_data_d  = C_CH_LF;
            tx_start_d = 1'b1;
            col_d      = 4'd0;
            if (idx_q == w_last_idx) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 8'd1;
              state_d = ST_RD_ISSUE;
            end
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      err_q       <= ERR_NONE;
      tx_data_q   <= 8'd0;
      tx_start_q  <= 1'b0;
      tx_hold_q   <= 1'b0;
      query_req_q <= 1'b0;
      slot_q      <= 4'd0;
      clear_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      m_q         <= 4'd0;
      n_q         <= 4'd0;
      base_q      <= '0;
      idx_q       <= 8'd0;
      col_q       <= 4'd0;
      data_q      <= 4'd0;
      miss_q      <= 1'b0;
      hdr_step_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      tx_hold_q   <= tx_hold_d;
      query_req_q <= query_req_d;
      slot_q      <= slot_d;
      clear_q     <= clear_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      m_q         <= m_d;
      n_q         <= n_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      col_q       <= col_d;
      data_q      <= data_d;
      miss_q      <= miss_d;
      hdr_step_q  <= hdr_step_d;
    end
  end

  assign clear_rx_buffer = clear_q;
  assign tx_data         = tx_data_q;
  assign tx_start        = tx_start_q;
  assign query_req       = query_req_q;
  assign query_slot      = slot_q;
  assign mem_rd_en       = rd_en_q;
  assign mem_rd_addr     = rd_addr_q;
  assign sub_state       = state_q;
  assign error_code      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_display_mode.sv
`default_nettype none
// ============================================================================
// Module  : tb_display_mode
// Purpose : Directed self-checking bench for display_mode. Surrounds the DUT
//           with a transmitter, slot-lookup responder and element memory,
//           then runs one task per scenario.
// Revision: 1.0 - initial release
// ============================================================================
module tb_display_mode;

  localparam int EW = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mode_active = 1'b0;
  logic          timeout_reset = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_done = 1'b0;
  logic          clear_rx_buffer;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic          query_req;
  logic [3:0]    query_slot;
  logic          query_valid = 1'b0;
  logic          query_hit = 1'b0;
  logic [3:0]    query_m = 4'd0;
  logic [3:0]    query_n = 4'd0;
  logic [AW-1:0] query_addr = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [EW-1:0] mem_rd_data = '0;
  logic [3:0]    sub_state;
  logic [3:0]    error_code;

  int checks = 0;
  int errors = 0;

  display_mode #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mode_active     (mode_active),
    .timeout_reset   (timeout_reset),
    .rx_data         (rx_data),
    .rx_done         (rx_done),
    .clear_rx_buffer (clear_rx_buffer),
    .tx_data         (tx_data),
    .tx_start        (tx_start),
    .tx_busy         (tx_busy),
    .query_req       (query_req),
    .query_slot      (query_slot),
    .query_valid     (query_valid),
    .query_hit       (query_hit),
    .query_m         (query_m),
    .query_n         (query_n),
    .query_addr      (query_addr),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_data     (mem_rd_data),
    .sub_state       (sub_state),
    .error_code      (error_code)
  );

  always #5 clk = ~clk;

  // ---------------- environment models ----------------
  logic [7:0]    txq[$];
  int            rdq[$];
  int            busy_cnt = 0;
  logic          hold_busy = 1'b0;
  logic          prev_start = 1'b0;
  int            back_to_back = 0;
  int            start_cnt = 0;
  int            clr_cnt = 0;
  logic [EW-1:0] mem [0:(1<<AW)-1];
  logic          hit_tab [0:15];
  logic [3:0]    m_tab [0:15];
  logic [3:0]    n_tab [0:15];
  logic [AW-1:0] a_tab [0:15];
  int            qdly = 0;

  assign tx_busy = (busy_cnt != 0) || hold_busy;

  always @(posedge clk) begin
    prev_start <= tx_start;
    if (tx_start && prev_start) back_to_back <= back_to_back + 1;
    if (tx_start) begin
      txq.push_back(tx_data);
      start_cnt <= start_cnt + 1;
      busy_cnt  <= 3;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (clear_rx_buffer) clr_cnt <= clr_cnt + 1;
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_rd_addr];
      rdq.push_back(int'(mem_rd_addr));
    end
    if (query_req && !query_valid) begin
      if (qdly == 2) begin
        query_valid <= 1'b1;
        query_hit   <= hit_tab[query_slot];
        query_m     <= m_tab[query_slot];
        query_n     <= n_tab[query_slot];
        query_addr  <= a_tab[query_slot];
        qdly        <= 0;
      end else begin
        qdly <= qdly + 1;
      end
    end else begin
      query_valid <= 1'b0;
    end
  end

  // Render a byte queue as text, line feeds shown as '/'.
  function automatic string q2s(input logic [7:0] q[$]);
    string s;
    s = "";
    foreach (q[i]) begin
      if (q[i] == 8'h0A) s = {s, "/"};
      else s = {s, string'(q[i])};
    end
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_tx(input int n, input string name);
    int cyc;
    cyc = 0;
    while (txq.size() < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (txq.size() < n) begin
      checks++; errors++;
      $display("FAIL %s: timeout, got %0d bytes, want %0d", name, txq.size(), n);
    end
  endtask

  task automatic wait_state(input logic [3:0] st, input string name);
    int cyc;
    cyc = 0;
    while (sub_state !== st && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (sub_state !== st) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting state %0d, at %0d", name, st, sub_state);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    mode_active = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (sub_state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", sub_state); end
    checks++; if (error_code !== 4'd0) begin errors++; $display("FAIL reset_err got %0d want 0", error_code); end
    checks++; if ({tx_start, query_req, mem_rd_en, clear_rx_buffer} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b want 0000", {tx_start, query_req, mem_rd_en, clear_rx_buffer}); end
    checks++; if (tx_data !== 8'd0 || query_slot !== 4'd0 || mem_rd_addr !== '0) begin errors++; $display("FAIL reset_regs tx_data %h slot %h addr %h want 0", tx_data, query_slot, mem_rd_addr); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (sub_state !== 4'd1) begin errors++; $display("FAIL idle_to_wait got %0d want 1", sub_state); end
  endtask

  task automatic test_bad_digit();
    int c0;
    txq.delete();
    c0 = clr_cnt;
    send_byte("Q");
    wait_tx(1, "bad_digit_tx");
    repeat (3) @(negedge clk);
    checks++; if (q2s(txq) != "!") begin errors++; $display("FAIL bad_digit_tx got '%s' want '!'", q2s(txq)); end
    checks++; if (error_code !== 4'd1) begin errors++; $display("FAIL bad_digit_err got %0d want 1", error_code); end
    checks++; if (clr_cnt - c0 != 1) begin errors++; $display("FAIL bad_digit_clear got %0d pulses want 1", clr_cnt - c0); end
    checks++; if (sub_state !== 4'd1) begin errors++; $display("FAIL bad_digit_state got %0d want 1", sub_state); end
  endtask

  task automatic test_slot_empty();
    txq.delete();
    send_byte("5");
    wait_tx(1, "empty_tx");
    repeat (3) @(negedge clk);
    checks++; if (q2s(txq) != "!") begin errors++; $display("FAIL empty_tx got '%s' want '!'", q2s(txq)); end
    checks++; if (error_code !== 4'd2) begin errors++; $display("FAIL empty_err got %0d want 2", error_code); end
    checks++; if (sub_state !== 4'd1) begin errors++; $display("FAIL empty_state got %0d want 1", sub_state); end
  endtask

  task automatic test_matrix_2x3();
    string exp;
    int    ra [6] = '{16, 17, 18, 19, 20, 21};
`ifdef DISPLAY_HEADER_EN
    exp = "2x3/1 2 3 /A B C /";
`else
    exp = "1 2 3 /A B C /";
`endif
    txq.delete(); rdq.delete();
    send_byte("2");
    wait_tx(exp.len(), "m2x3_tx");
    wait_state(4'd1, "m2x3_end");
    repeat (5) @(negedge clk);
    checks++; if (q2s(txq) != exp) begin errors++; $display("FAIL m2x3_tx got '%s' want '%s'", q2s(txq), exp); end
    checks++; if (rdq.size() != 6) begin errors++; $display("FAIL m2x3_nreads got %0d want 6", rdq.size()); end
    for (int i = 0; i < 6 && i < rdq.size(); i++) begin
      checks++; if (rdq[i] != ra[i]) begin errors++; $display("FAIL m2x3_addr[%0d] got %0h want %0h", i, rdq[i], ra[i]); end
    end
    checks++; if (error_code !== 4'd0) begin errors++; $display("FAIL m2x3_err got %0d want 0", error_code); end
  endtask

  task automatic test_1x1_edge();
    string exp;
`ifdef DISPLAY_HEADER_EN
    exp = "1x1/F /";
`else
    exp = "F /";
`endif
    txq.delete(); rdq.delete();
    send_byte("7");
    wait_tx(exp.len(), "m1x1_tx");
    wait_state(4'd1, "m1x1_end");
    repeat (5) @(negedge clk);
    checks++; if (q2s(txq) != exp) begin errors++; $display("FAIL m1x1_tx got '%s' want '%s'", q2s(txq), exp); end
    checks++; if (rdq.size() != 1 || rdq[0] != 1023) begin errors++; $display("FAIL m1x1_addr got n=%0d a=%0h want n=1 a=3ff", rdq.size(), (rdq.size() > 0) ? rdq[0] : -1); end
  endtask

  task automatic test_busy_stall();
    string exp;
    int    s0;
`ifdef DISPLAY_HEADER_EN
    exp = "2x3/1 2 3 /A B C /";
`else
    exp = "1 2 3 /A B C /";
`endif
    txq.delete();
    send_byte("2");
    wait_tx(exp.len() - 10, "stall_pre");
    hold_busy = 1'b1;
    s0 = start_cnt;
    repeat (50) @(negedge clk);
    checks++; if (start_cnt != s0) begin errors++; $display("FAIL stall_starts got %0d want 0", start_cnt - s0); end
    hold_busy = 1'b0;
    wait_tx(exp.len(), "stall_tx");
    wait_state(4'd1, "stall_end");
    repeat (5) @(negedge clk);
    checks++; if (q2s(txq) != exp) begin errors++; $display("FAIL stall_tx got '%s' want '%s'", q2s(txq), exp); end
  endtask

  task automatic test_reset_mid();
    string exp;
`ifdef DISPLAY_HEADER_EN
    exp = "3x3/0 1 2 /3 4 5 /6 7 8 /";
`else
    exp = "0 1 2 /3 4 5 /6 7 8 /";
`endif
    txq.delete();
    send_byte("3");
    wait_state(4'd7, "rstmid_reach");
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sub_state !== 4'd0 || error_code !== 4'd0) begin errors++; $display("FAIL rstmid_state got st %0d err %0d want 0 0", sub_state, error_code); end
    checks++; if ({tx_start, query_req, mem_rd_en, clear_rx_buffer} !== 4'b0 || tx_data !== 8'd0 || query_slot !== 4'd0 || mem_rd_addr !== '0) begin
      errors++; $display("FAIL rstmid_outs got pulses %b tx %h slot %h addr %h want 0", {tx_start, query_req, mem_rd_en, clear_rx_buffer}, tx_data, query_slot, mem_rd_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    txq.delete();
    wait_state(4'd1, "rstmid_idle");
    send_byte("3");
    wait_tx(exp.len(), "rstmid_tx");
    wait_state(4'd1, "rstmid_end");
    repeat (5) @(negedge clk);
    checks++; if (q2s(txq) != exp) begin errors++; $display("FAIL rstmid_tx got '%s' want '%s'", q2s(txq), exp); end
  endtask

  task automatic test_mode_drop();
    int n0;
    txq.delete();
    send_byte("2");
    wait_tx(3, "drop_pre");
    mode_active = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n0 = txq.size();
    checks++; if (sub_state !== 4'd0 || query_req !== 1'b0 || mem_rd_en !== 1'b0) begin errors++; $display("FAIL drop_outs got st %0d req %b rd %b want 0 0 0", sub_state, query_req, mem_rd_en); end
    repeat (20) @(negedge clk);
    checks++; if (txq.size() != n0) begin errors++; $display("FAIL drop_bytes got %0d extra want 0", txq.size() - n0); end
    mode_active = 1'b1;
    wait_state(4'd1, "drop_resume");
  endtask

  task automatic test_timeout();
    wait_state(4'd1, "tmo_pre");
    timeout_reset = 1'b1;
    @(negedge clk);
    timeout_reset = 1'b0;
    checks++; if (sub_state !== 4'd0) begin errors++; $display("FAIL timeout_state got %0d want 0", sub_state); end
    @(negedge clk);
    checks++; if (sub_state !== 4'd1) begin errors++; $display("FAIL timeout_resume got %0d want 1", sub_state); end
  endtask

  task automatic test_back_to_back();
    checks++; if (back_to_back != 0) begin errors++; $display("FAIL tx_start_consecutive got %0d want 0", back_to_back); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) begin
      hit_tab[i] = 1'b0; m_tab[i] = 4'd0; n_tab[i] = 4'd0; a_tab[i] = '0;
    end
    hit_tab[2] = 1'b1; m_tab[2] = 4'd2; n_tab[2] = 4'd3; a_tab[2] = 10'h010;
    mem[10'h010] = 8'h01; mem[10'h011] = 8'h02; mem[10'h012] = 8'h03;
    mem[10'h013] = 8'h0A; mem[10'h014] = 8'h0B; mem[10'h015] = 8'h0C;
    hit_tab[7] = 1'b1; m_tab[7] = 4'd1; n_tab[7] = 4'd1; a_tab[7] = 10'h3FF;
    mem[10'h3FF] = 8'hAF;
    hit_tab[3] = 1'b1; m_tab[3] = 4'd3; n_tab[3] = 4'd3; a_tab[3] = 10'h040;
    for (int i = 0; i < 9; i++) mem[10'h040 + i] = 8'(i);

    test_reset();
    test_bad_digit();
    test_slot_empty();
    test_matrix_2x3();
    test_1x1_edge();
    test_busy_stall();
    test_timeout();
    test_mode_drop();
    test_reset_mid();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
